jt900h_prefetch: RTL and testbench



---
 rtl/jt900h_pkg.sv | 27 ++
 rtl/jt900h_pfq_buf.sv | 84 ++++++++
 rtl/jt900h_prefetch.sv | 156 +++++++++++++++
 tb/tb_jt900h_prefetch.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h instruction prefetch path.
// Contents:
//   - pf_state_e  : prefetch FSM encodings (StIdle / StRead / StDiscard)
//   - QW_DEF      : default prefetch queue depth in bytes
//   - PCW_DEF     : default address width
//   - FETCH_W     : width of the control stage's byte-consumed count
//   - clamp_fetch : limits a consume request to the bytes actually held
package jt900h_pkg;

    localparam int unsigned QW_DEF  = 8;
    localparam int unsigned PCW_DEF = 24;
    localparam int unsigned FETCH_W = 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRead    = 2'd1,
        StDiscard = 2'd2
    } pf_state_e;

    // A request for more bytes than are queued only retires what is there.
    function automatic logic [FETCH_W-1:0] clamp_fetch(input logic [FETCH_W-1:0] fetched,
                                                       input int unsigned count);
        if (32'(fetched) > count) return FETCH_W'(count);
        return fetched;
    endfunction

endpackage

// File: rtl/jt900h_pfq_buf.sv
// Circular byte queue for the prefetch unit.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   cen          : clock enable for all state
//   flush        : empty the queue (pointers back to 0)
//   we, skip_lo  : write din as two bytes, or only din[15:8] when skip_lo
//   din          : 16-bit bus word, [7:0] is the even byte
//   rd_n         : bytes retired this cycle (already clamped to count)
//   window       : bytes rd..rd+3, window[7:0] is the oldest
//   count        : number of valid bytes held
module jt900h_pfq_buf
    import jt900h_pkg::*;
#(
    parameter int unsigned QW = QW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 flush,
    input  logic                 we,
    input  logic                 skip_lo,
    input  logic [15:0]          din,
    input  logic [FETCH_W-1:0]   rd_n,
    output logic [31:0]          window,
    output logic [$clog2(QW):0]  count
);

    localparam int unsigned AW = $clog2(QW);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [QW];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    n_wr;

    always_comb begin
        n_wr    = we ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            rd_d    = rd_q + AW'(rd_n);
            wr_d    = wr_q + AW'(n_wr);
            count_d = count_q - CW'(rd_n) + CW'(n_wr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (cen) begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QW; i++) mem_q[i] <= '0;
        end else if (cen && we && !flush) begin
            if (skip_lo) begin
                mem_q[wr_q] <= din[15:8];
            end else begin
                mem_q[wr_q]           <= din[7:0];
                mem_q[wr_q + AW'(1)]  <= din[15:8];
            end
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < 4; i++) window[8*i +: 8] = mem_q[rd_q + AW'(i)];
    end

    assign count = count_q;

endmodule

// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue feeding the jt900h control stage.
// Reads program memory 16 bits at a time into a QW-byte circular queue and
// presents a 4-byte little-endian window at the current PC.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   cen           : clock enable qualifying every state update
//   pc_we, pc_in  : jump: load PC, flush queue, restart reads at pc_in
//   pc            : address of op[7:0]
//   fetched       : bytes retired by the control stage this cycle (0..3)
//   op, op_ok     : byte window and "at least 4 bytes valid"
//   bus_addr      : word-aligned read address
//   bus_rd        : read request, held until bus_ok
//   bus_din       : read data, [7:0] is the even byte
//   bus_ok        : read data valid
//   underrun_err  : sticky over-consume flag, only with JT900H_PREFETCH_ERR_EN
//                   defined; tied low otherwise
module jt900h_prefetch
    import jt900h_pkg::*;
#(
    parameter int unsigned QW  = QW_DEF,
    parameter int unsigned PCW = PCW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               pc_we,
    input  logic [PCW-1:0]     pc_in,
    output logic [PCW-1:0]     pc,
    input  logic [FETCH_W-1:0] fetched,
    output logic [31:0]        op,
    output logic               op_ok,
    output logic [PCW-1:0]     bus_addr,
    output logic               bus_rd,
    input  logic [15:0]        bus_din,
    input  logic               bus_ok,
    output logic               underrun_err
);

    localparam int unsigned CW = $clog2(QW) + 1;
    localparam logic [CW-1:0] FILL_MAX = CW'(QW - 2);

    pf_state_e          state_q, state_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [PCW-1:0]     faddr_q, faddr_d;
    logic [PCW-1:0]     addr_q, addr_d;
    logic               skip_q, skip_d;
    logic [CW-1:0]      count;
    logic [FETCH_W-1:0] cons, buf_rd_n;
    logic               buf_we, buf_flush;
    logic [CW-1:0]      post_idle, post_wr;
    logic [PCW-1:0]     faddr_inc;

    assign cons      = clamp_fetch(fetched, 32'(count));
    assign buf_rd_n  = (cen && !pc_we) ? cons : '0;
    // Occupancy after this cycle, without and with the word landing now
    assign post_idle = count - CW'(cons);
    assign post_wr   = post_idle + (skip_q ? CW'(1) : CW'(2));
    assign faddr_inc = faddr_q + PCW'(2);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        faddr_d   = faddr_q;
        addr_d    = addr_q;
        skip_d    = skip_q;
        buf_we    = 1'b0;
        buf_flush = 1'b0;
        if (cen) begin
            if (pc_we) begin
                buf_flush = 1'b1;
                pc_d      = pc_in;
                faddr_d   = {pc_in[PCW-1:1], 1'b0};
                skip_d    = pc_in[0];
            end else begin
                pc_d = pc_q + PCW'(cons);
            end
            unique case (state_q)
                StIdle: begin
                    if (!pc_we && post_idle <= FILL_MAX) begin
                        state_d = StRead;
                        addr_d  = faddr_q;
                    end
                end
                StRead: begin
                    if (pc_we) begin
                        // In-flight word belongs to the old stream
                        state_d = bus_ok ? StIdle : StDiscard;
                    end else if (bus_ok) begin
                        buf_we  = 1'b1;
                        skip_d  = 1'b0;
                        faddr_d = faddr_inc;
                        if (post_wr <= FILL_MAX) addr_d = faddr_inc;
                        else state_d = StIdle;
                    end
                end
                StDiscard: begin
                    if (bus_ok) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            faddr_q <= '0;
            addr_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            addr_q  <= addr_d;
            skip_q  <= skip_d;
        end
    end

    jt900h_pfq_buf #(
        .QW (QW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .flush   (buf_flush),
        .we      (buf_we),
        .skip_lo (skip_q),
        .din     (bus_din),
        .rd_n    (buf_rd_n),
        .window  (op),
        .count   (count)
    );

    assign pc       = pc_q;
    assign bus_addr = addr_q;
    assign bus_rd   = (state_q != StIdle);
    assign op_ok    = (count >= CW'(4));

`ifdef JT900H_PREFETCH_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cen && !pc_we && (CW'(fetched) > count)) begin
            err_q <= 1'b1;
        end
    end

    assign underrun_err = err_q;
`else
    assign underrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_jt900h_prefetch.sv
module tb_jt900h_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        pc_we = 1'b0;
    logic [23:0] pc_in = '0;
    logic [23:0] pc;
    logic [1:0]  fetched = '0;
    logic [31:0] op;
    logic        op_ok;
    logic [23:0] bus_addr;
    logic        bus_rd;
    logic [15:0] bus_din;
    logic        bus_ok;
    logic        underrun_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [23:0] pc;
        logic [31:0] op;
    } exp_t;
    exp_t exp_q[$];
    logic [23:0] rdlog[$];
    logic [23:0] m_pc;

    int waits = 0;
    int wcnt  = 0;

    always #5 clk = ~clk;

    jt900h_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .pc_we        (pc_we),
        .pc_in        (pc_in),
        .pc           (pc),
        .fetched      (fetched),
        .op           (op),
        .op_ok        (op_ok),
        .bus_addr     (bus_addr),
        .bus_rd       (bus_rd),
        .bus_din      (bus_din),
        .bus_ok       (bus_ok),
        .underrun_err (underrun_err)
    );

    function automatic logic [7:0] mem_b(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    function automatic logic [31:0] window(input logic [23:0] a);
        return {mem_b(a + 24'd3), mem_b(a + 24'd2), mem_b(a + 24'd1), mem_b(a)};
    endfunction

    // Memory model: data valid once the request has waited `waits` cycles
    assign bus_din = {mem_b(bus_addr + 24'd1), mem_b(bus_addr)};
    assign bus_ok  = bus_rd && (wcnt >= waits);

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus_rd && cen) wcnt <= bus_ok ? 0 : wcnt + 1;
    end

    always @(posedge clk) begin
        if (!rst && cen && bus_ok) rdlog.push_back(bus_addr);
    end

    task automatic wait_op_ok(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (op_ok) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (pc !== 24'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 000000", pc); end
        n_cmp++; if (bus_rd !== 1'b0) begin n_bad++; $display("FAIL reset_bus_rd: got %b expected 0", bus_rd); end
        n_cmp++; if (bus_addr !== 24'h0) begin n_bad++; $display("FAIL reset_bus_addr: got %h expected 000000", bus_addr); end
        n_cmp++; if (op !== 32'h0) begin n_bad++; $display("FAIL reset_op: got %h expected 00000000", op); end
        n_cmp++; if (op_ok !== 1'b0) begin n_bad++; $display("FAIL reset_op_ok: got %b expected 0", op_ok); end
        n_cmp++; if (underrun_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", underrun_err); end
        rst = 1'b0;
    endtask

    task automatic test_fill;
        waits = 0;
        rdlog.delete();
        repeat (12) @(negedge clk);
        n_cmp++;
        if (rdlog.size() != 4) begin
            n_bad++; $display("FAIL fill_reads: got %0d expected 4", rdlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rdlog[i] !== 24'(2 * i)) begin
                    n_bad++; $display("FAIL fill_addr[%0d]: got %h expected %h", i, rdlog[i], 24'(2 * i));
                end
            end
        end
        n_cmp++; if (bus_rd !== 1'b0) begin n_bad++; $display("FAIL fill_bus_rd: got %b expected 0", bus_rd); end
        n_cmp++; if (dut.u_buf.count_q !== 4'd8) begin n_bad++; $display("FAIL fill_count: got %0d expected 8", dut.u_buf.count_q); end
        n_cmp++; if (op !== 32'h03020100) begin n_bad++; $display("FAIL fill_op: got %h expected 03020100", op); end
        n_cmp++; if (op_ok !== 1'b1) begin n_bad++; $display("FAIL fill_op_ok: got %b expected 1", op_ok); end
        n_cmp++; if (pc !== 24'h0) begin n_bad++; $display("FAIL fill_pc: got %h expected 000000", pc); end
    endtask

    task automatic test_stream;
        bit   ok;
        exp_t e;
        m_pc = 24'h0;
        exp_q.push_back('{pc: m_pc, op: window(m_pc)});
        for (int k = 0; k < 9; k++) begin
            wait_op_ok(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL stream_timeout[%0d]: got op_ok 0 expected 1", k);
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            n_cmp++; if (op !== e.op) begin n_bad++; $display("FAIL stream_op[%0d]: got %h expected %h", k, op, e.op); end
            n_cmp++; if (pc !== e.pc) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, pc, e.pc); end
            if (k < 8) begin
                fetched = 2'd3;
                m_pc    = m_pc + 24'd3;
                exp_q.push_back('{pc: m_pc, op: window(m_pc)});
                @(negedge clk);
                fetched = 2'd0;
            end
        end
    endtask

    task automatic test_cen;
        cen     = 1'b0;
        fetched = 2'd3;
        repeat (3) @(negedge clk);
        n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL cen_pc: got %h expected %h", pc, m_pc); end
        n_cmp++; if (op !== window(m_pc)) begin n_bad++; $display("FAIL cen_op: got %h expected %h", op, window(m_pc)); end
        fetched = 2'd0;
        cen     = 1'b1;
    endtask

    task automatic test_jump_odd;
        bit   ok;
        exp_t e;
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        waits = 3;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_rd && bus_addr == 24'h6) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL jump_reach6: got no read at 6 expected read at 000006"); return; end
        rdlog.delete();
        pc_we = 1'b1;
        pc_in = 24'h000105;
        @(negedge clk);
        pc_we = 1'b0;
        m_pc  = 24'h000105;
        exp_q.push_back('{pc: m_pc, op: window(m_pc)});
        wait_op_ok(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL jump_timeout: got op_ok 0 expected 1"); exp_q.delete(); return; end
        e = exp_q.pop_front();
        n_cmp++; if (op !== e.op) begin n_bad++; $display("FAIL jump_op: got %h expected %h", op, e.op); end
        n_cmp++; if (pc !== e.pc) begin n_bad++; $display("FAIL jump_pc: got %h expected %h", pc, e.pc); end
        n_cmp++;
        if (rdlog.size() < 2) begin
            n_bad++; $display("FAIL jump_reads: got %0d reads expected >=2", rdlog.size());
        end else begin
            n_cmp++; if (rdlog[0] !== 24'h6) begin n_bad++; $display("FAIL jump_discard_addr: got %h expected 000006", rdlog[0]); end
            n_cmp++; if (rdlog[1] !== 24'h104) begin n_bad++; $display("FAIL jump_new_addr: got %h expected 000104", rdlog[1]); end
        end
    endtask

    task automatic test_simul;
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!bus_rd) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL simul_idle: got bus_rd 1 expected 0"); return; end
        n_cmp++; if (dut.u_buf.count_q !== 4'd7) begin n_bad++; $display("FAIL simul_count7: got %0d expected 7", dut.u_buf.count_q); end
        fetched = 2'd1;
        m_pc    = m_pc + 24'd1;
        exp_q.push_back('{pc: m_pc, op: window(m_pc)});
        @(negedge clk);
        fetched = 2'd0;
        e = exp_q.pop_front();
        n_cmp++; if (op !== e.op) begin n_bad++; $display("FAIL simul_op1: got %h expected %h", op, e.op); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_ok) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL simul_bus_ok: got no bus_ok expected bus_ok"); return; end
        n_cmp++; if (bus_addr !== 24'h10c) begin n_bad++; $display("FAIL simul_addr: got %h expected 00010c", bus_addr); end
        fetched = 2'd2;
        m_pc    = m_pc + 24'd2;
        exp_q.push_back('{pc: m_pc, op: window(m_pc)});
        @(negedge clk);
        fetched = 2'd0;
        n_cmp++; if (dut.u_buf.count_q !== 4'd6) begin n_bad++; $display("FAIL simul_count: got %0d expected 6", dut.u_buf.count_q); end
        e = exp_q.pop_front();
        n_cmp++; if (op !== e.op) begin n_bad++; $display("FAIL simul_op2: got %h expected %h", op, e.op); end
        n_cmp++; if (pc !== e.pc) begin n_bad++; $display("FAIL simul_pc: got %h expected %h", pc, e.pc); end
    endtask

    task automatic test_wrap;
        bit   ok;
        exp_t e;
        waits = 0;
        pc_we = 1'b1;
        pc_in = 24'hfffffe;
        @(negedge clk);
        pc_we = 1'b0;
        rdlog.delete();
        m_pc = 24'hfffffe;
        exp_q.push_back('{pc: m_pc, op: window(m_pc)});
        wait_op_ok(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got op_ok 0 expected 1"); exp_q.delete(); return; end
        e = exp_q.pop_front();
        n_cmp++; if (op !== e.op) begin n_bad++; $display("FAIL wrap_op: got %h expected %h", op, e.op); end
        n_cmp++;
        if (rdlog.size() < 2) begin
            n_bad++; $display("FAIL wrap_reads: got %0d reads expected >=2", rdlog.size());
        end else begin
            n_cmp++; if (rdlog[0] !== 24'hfffffe) begin n_bad++; $display("FAIL wrap_addr0: got %h expected fffffe", rdlog[0]); end
            n_cmp++; if (rdlog[1] !== 24'h000000) begin n_bad++; $display("FAIL wrap_addr1: got %h expected 000000", rdlog[1]); end
        end
        fetched = 2'd2;
        m_pc    = m_pc + 24'd2;
        exp_q.push_back('{pc: m_pc, op: window(m_pc)});
        @(negedge clk);
        fetched = 2'd0;
        wait_op_ok(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wrap_timeout2: got op_ok 0 expected 1"); exp_q.delete(); return; end
        e = exp_q.pop_front();
        n_cmp++; if (pc !== e.pc) begin n_bad++; $display("FAIL wrap_pc: got %h expected %h", pc, e.pc); end
        n_cmp++; if (op !== e.op) begin n_bad++; $display("FAIL wrap_op2: got %h expected %h", op, e.op); end
    endtask

    task automatic test_underrun;
        bit   ok;
        logic exp_err;
`ifdef JT900H_PREFETCH_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        waits = 3;
        pc_we = 1'b1;
        pc_in = 24'h000201;
        @(negedge clk);
        pc_we = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dut.u_buf.count_q == 4'd1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL under_reach: got count %0d expected 1", dut.u_buf.count_q); return; end
        fetched = 2'd3;
        @(negedge clk);
        fetched = 2'd0;
        n_cmp++; if (dut.u_buf.count_q !== 4'd0) begin n_bad++; $display("FAIL under_count: got %0d expected 0", dut.u_buf.count_q); end
        n_cmp++; if (pc !== 24'h000202) begin n_bad++; $display("FAIL under_pc: got %h expected 000202", pc); end
        n_cmp++; if (underrun_err !== exp_err) begin n_bad++; $display("FAIL under_err: got %b expected %b", underrun_err, exp_err); end
        repeat (10) @(negedge clk);
        n_cmp++; if (underrun_err !== exp_err) begin n_bad++; $display("FAIL under_sticky: got %b expected %b", underrun_err, exp_err); end
    endtask

    task automatic test_async_reset;
        bit ok;
        waits = 5;
        pc_we = 1'b1;
        pc_in = 24'h000300;
        @(negedge clk);
        pc_we = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_rd) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL areset_reach: got bus_rd 0 expected 1"); return; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_rd !== 1'b0) begin n_bad++; $display("FAIL areset_bus_rd: got %b expected 0", bus_rd); end
        n_cmp++; if (underrun_err !== 1'b0) begin n_bad++; $display("FAIL areset_err: got %b expected 0", underrun_err); end
        n_cmp++; if (pc !== 24'h0) begin n_bad++; $display("FAIL areset_pc: got %h expected 000000", pc); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_stream;
        test_cen;
        test_jump_odd;
        test_simul;
        test_wrap;
        test_underrun;
        test_async_reset;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
